gf_inv_div: RTL and testbench

- Sequential GF(2^8) inverse/divide unit over the AES field polynomial x^8+x^4+x^3+x+1 (0x11B).
- Counterpart of the combinational field multiplier on the encryption side: it computes a^-1, or num/den = num·den^-1.
- Serves the decryption datapath (inverse S-box inversion stage, key-schedule checks) where area matters more than latency.
- Inversion is a^254, computed by square-and-multiply, one exponent bit per clock.

---
 rtl/gf_inv_div.sv | 105 ++++++++++
 tb/tb_gf_inv_div.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gf_inv_div.sv
// Sequential GF(2^8) inverse / divide over x^8+x^4+x^3+x+1.
// The inverse is a^EXP by MSB-first square-and-multiply, one exponent bit per clock.
module gf_inv_div #(
  parameter logic [7:0] POLY = 8'h1B,
  parameter logic [7:0] EXP  = 8'hFE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       op,
  input  logic [7:0] num,
  input  logic [7:0] den,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_EXP  = 4'b0010,
    ST_MUL  = 4'b0100,
    ST_DONE = 4'b1000
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] acc;
  logic [7:0] a_r;
  logic [7:0] n_r;
  logic       op_r;
  logic [2:0] cnt;
  logic [7:0] acc_sq;
  logic [7:0] acc_nxt;

  // Shift-and-add GF multiply; each shift is an xtime with conditional reduction.
  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? POLY : 8'h00);
    end
    return p;
  endfunction

  always_comb begin
    acc_sq  = gf_mul(acc, acc);
    acc_nxt = EXP[cnt] ? gf_mul(acc_sq, a_r) : acc_sq;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid)     state_nxt = ST_EXP;
      ST_EXP:  if (cnt == 3'd0)  state_nxt = op_r ? ST_MUL : ST_DONE;
      ST_MUL:                    state_nxt = ST_DONE;
      ST_DONE: if (out_ready)    state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= 8'h00;
      a_r    <= 8'h00;
      n_r    <= 8'h00;
      op_r   <= 1'b0;
      cnt    <= 3'd0;
      result <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r  <= den;
            n_r  <= num;
            op_r <= op;
            acc  <= 8'h01;
            cnt  <= 3'd7;
          end
        end
        ST_EXP: begin
          acc <= acc_nxt;
          cnt <= cnt - 3'd1;
          // Inverse-only results complete here; divides take one more cycle.
          if (cnt == 3'd0 && !op_r) result <= acc_nxt;
        end
        ST_MUL:  result <= gf_mul(n_r, acc);
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_EXP) || (state == ST_MUL);

endmodule

// File: tb/tb_gf_inv_div.sv
// Randomized self-checking bench for gf_inv_div against a polynomial-arithmetic
// reference (carry-less product, long-division reduction, brute-force inverse).
module tb_gf_inv_div;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       op;
  logic [7:0] num;
  logic [7:0] den;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic       busy;

  int checks = 0;
  int failures = 0;

  gf_inv_div dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .num       (num),
    .den       (den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] prod;
    logic [15:0] poly16;
    prod   = 16'h0000;
    poly16 = 16'h011B;
    for (int i = 0; i < 8; i++)
      if (y[i]) prod = prod ^ (16'(x) << i);
    for (int b = 15; b >= 8; b--)
      if (prod[b]) prod = prod ^ (poly16 << (b - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int b = 1; b < 256; b++)
      if (ref_mul(x, 8'(b)) == 8'h01) return 8'(b);
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_op(input logic o, input logic [7:0] nm, input logic [7:0] dn);
    return o ? ref_mul(nm, ref_inv(dn)) : ref_inv(dn);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Launches one operation, waits (bounded) for out_valid and returns the result and latency.
  task automatic do_op(input logic o, input logic [7:0] nm, input logic [7:0] dn,
                       input bit scramble, output logic [7:0] res, output int lat);
    @(negedge clk);
    chk("accept_ready", in_ready, 1);
    op = o; num = nm; den = dn; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (scramble) begin
        op = 1'($urandom); num = 8'($urandom); den = 8'($urandom);
      end
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
      if (k == 1) begin
        chk("run_busy", busy, 1);
        chk("run_in_ready", in_ready, 0);
      end
    end
    res = result;
    chk("latency", lat, o ? 9 : 8);
    if (out_ready && lat != 0) begin
      @(posedge clk); #1;
      chk("handoff_out_valid", out_valid, 0);
      chk("handoff_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    logic [7:0] res, held, o_n, o_d;
    logic       o_op;
    int         lat;
    logic [7:0] inv_den [3];
    logic [7:0] inv_exp [3];

    reset = 1'b1; in_valid = 1'b0; op = 1'b0; num = 8'h00; den = 8'h00; out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 8'h00);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_op(1'b0, 8'h00, 8'h53, 1'b0, res, lat);
    chk("inv_53", res, 8'hCA);

    inv_den = '{8'h02, 8'h01, 8'h00};
    inv_exp = '{8'h8D, 8'h01, 8'h00};
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 8'h00, inv_den[i], 1'b0, res, lat);
      chk("inv_sweep", res, inv_exp[i]);
    end

    for (int d = 1; d < 256; d++) begin
      do_op(1'b0, 8'($urandom), 8'(d), 1'b0, res, lat);
      chk("inv_product", ref_mul(res, 8'(d)), 8'h01);
    end

    do_op(1'b1, 8'hC1, 8'h83, 1'b0, res, lat);
    chk("div_c1_83", res, 8'h57);
    do_op(1'b1, 8'hAB, 8'h00, 1'b0, res, lat);
    chk("div_ab_00", res, 8'h00);
    do_op(1'b1, 8'h3C, 8'h01, 1'b0, res, lat);
    chk("div_by_one", res, 8'h3C);

    for (int i = 0; i < 60; i++) begin
      o_op = 1'($urandom); o_n = 8'($urandom); o_d = 8'($urandom);
      do_op(o_op, o_n, o_d, 1'b0, res, lat);
      chk("rand_op", res, ref_op(o_op, o_n, o_d));
    end

    // Inputs wiggle every cycle while the unit is busy.
    for (int i = 0; i < 20; i++) begin
      o_op = 1'($urandom); o_n = 8'($urandom); o_d = 8'($urandom);
      do_op(o_op, o_n, o_d, 1'b1, res, lat);
      chk("scramble_op", res, ref_op(o_op, o_n, o_d));
      in_valid = 1'b0;
    end

    // Backpressure: result must hold and a second request must be ignored.
    out_ready = 1'b0;
    do_op(1'b1, 8'hC1, 8'h83, 1'b0, res, lat);
    chk("bp_result", res, 8'h57);
    held = result;
    @(negedge clk);
    in_valid = 1'b1; op = 1'b0; den = 8'h02;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_result_stable", result, held);
      chk("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_handoff_valid", out_valid, 0);
    chk("bp_handoff_ready", in_ready, 1);
    chk("bp_result_kept", result, 8'h57);
    do_op(1'b0, 8'h00, 8'h02, 1'b0, res, lat);
    chk("bp_next_op", res, 8'h8D);

    // Asynchronous reset mid-exponentiation.
    @(negedge clk);
    op = 1'b0; den = 8'h53; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_result", result, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("arst_hold_valid", out_valid, 0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("arst_no_valid", out_valid, 0);
    end
    do_op(1'b0, 8'h00, 8'h53, 1'b0, res, lat);
    chk("arst_fresh_op", res, 8'hCA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
